// File: rtl/lif_neuron_if.sv
// ---------------------------------------------------------------------------
// lif_neuron_if -- synapse weight stream into the LIF neuron.
//   w_in     : signed 8-bit synapse weight (registered synapse read data)
//   w_valid  : w_in is valid this cycle
//   in_ready : neuron is integrating; weights offered while low are dropped
// master = weight source (synapse array), slave = neuron.
// ---------------------------------------------------------------------------
interface lif_neuron_if;
  logic signed [7:0] w_in;
  logic              w_valid;
  logic              in_ready;

  modport master (output w_in, output w_valid, input in_ready);
  modport slave  (input w_in, input w_valid, output in_ready);
endinterface

// File: rtl/lif_neuron.sv
// ---------------------------------------------------------------------------
// lif_neuron -- leaky integrate-and-fire neuron.
// Integrates signed synapse weights into a saturating 16-bit membrane
// potential. On each timestep tick it evaluates the threshold once. It then
// either fires a one-cycle spike followed by a refractory hold-off, or leaks.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   kill      : synchronous clear, same values as reset
//   tick      : end-of-timestep strobe (one cycle)
//   syn       : weight stream (lif_neuron_if.slave: w_in, w_valid, in_ready)
//   spike_out : registered one-cycle spike pulse
//   vmem_out  : registered signed membrane potential
//   spike_cnt : spikes since reset/kill, wraps 0xFFFF -> 0
//
// Build option: define LIF_LEAK_EN to apply the leak
// vmem -= vmem >>> LEAK_SHIFT on the no-spike evaluation path. Without it
// the neuron is pure integrate-and-fire and LEAK_SHIFT has no effect.
// ---------------------------------------------------------------------------
module lif_neuron #(
  parameter logic signed [15:0] VTH        = 16'sd256,
  parameter int unsigned        LEAK_SHIFT = 3,
  parameter int unsigned        REFRAC     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               kill,
  input  logic               tick,
  lif_neuron_if.slave        syn,
  output logic               spike_out,
  output logic signed [15:0] vmem_out,
  output logic [15:0]        spike_cnt
);

  localparam int unsigned CW = (REFRAC < 2) ? 1 : $clog2(REFRAC + 1);

  if (LEAK_SHIFT < 1 || LEAK_SHIFT > 15) begin : g_bad_leak_shift
    $error("lif_neuron: LEAK_SHIFT must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_INTEG  = 2'd0,
    S_EVAL   = 2'd1,
    S_REFRAC = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic signed [15:0] vmem_q, vmem_d;
  logic               spike_q, spike_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [CW-1:0]      refc_q, refc_d;

  logic [16:0]        sum17;
  logic [15:0]        sat_sum;

  // 17-bit sum cannot overflow; disagreeing top bits mean 16-bit overflow.
  always_comb begin
    sum17 = {vmem_q[15], vmem_q} + {{9{syn.w_in[7]}}, syn.w_in};
    if (sum17[16] != sum17[15]) begin
      sat_sum = sum17[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      sat_sum = sum17[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    vmem_d  = vmem_q;
    spike_d = 1'b0;
    cnt_d   = cnt_q;
    refc_d  = refc_q;
    if (kill) begin
      state_d = S_INTEG;
      vmem_d  = '0;
      cnt_d   = '0;
      refc_d  = '0;
    end else begin
      unique case (state_q)
        S_INTEG: begin
          if (syn.w_valid) vmem_d = sat_sum;
          if (tick)        state_d = S_EVAL;
        end
        S_EVAL: begin
          if (vmem_q >= VTH) begin
            spike_d = 1'b1;
            vmem_d  = '0;
            cnt_d   = cnt_q + 16'd1;
            refc_d  = CW'(REFRAC);
            state_d = (REFRAC == 0) ? S_INTEG : S_REFRAC;
          end else begin
`ifdef LIF_LEAK_EN
            // Arithmetic shift floors toward -inf, so the subtraction always
            // moves toward 0 and never crosses it (-1 -> 0).
            vmem_d = vmem_q - (vmem_q >>> LEAK_SHIFT);
`endif
            state_d = S_INTEG;
          end
        end
        S_REFRAC: begin
          vmem_d = '0;
          if (tick) begin
            refc_d = refc_q - CW'(1);
            if (refc_q == CW'(1)) state_d = S_INTEG;
          end
        end
        default: state_d = S_INTEG;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INTEG;
      vmem_q  <= '0;
      spike_q <= 1'b0;
      cnt_q   <= '0;
      refc_q  <= '0;
    end else begin
      state_q <= state_d;
      vmem_q  <= vmem_d;
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
      refc_q  <= refc_d;
    end
  end

  assign syn.in_ready = (state_q == S_INTEG);
  assign spike_out    = spike_q;
  assign vmem_out     = vmem_q;
  assign spike_cnt    = cnt_q;

endmodule

// File: tb/tb_lif_neuron.sv
// ---------------------------------------------------------------------------
// tb_lif_neuron -- self-checking bench for lif_neuron (VTH=256,
// LEAK_SHIFT=3, REFRAC=2). A behavioural neuron model (integers, floor
// division for the leak) predicts every output after each clock edge.
// ---------------------------------------------------------------------------
module tb_lif_neuron;

  localparam int VTH_I   = 256;
  localparam int SHIFT_I = 3;
  localparam int REF_I   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               kill = 1'b0;
  logic               tick = 1'b0;
  logic               spike_out;
  logic signed [15:0] vmem_out;
  logic [15:0]        spike_cnt;

  lif_neuron_if bus ();

  lif_neuron #(
    .VTH        (16'sd256),
    .LEAK_SHIFT (SHIFT_I),
    .REFRAC     (REF_I)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .kill      (kill),
    .tick      (tick),
    .syn       (bus),
    .spike_out (spike_out),
    .vmem_out  (vmem_out),
    .spike_cnt (spike_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int mv;        // membrane potential
  int mcnt;      // spike counter
  bit mspk;      // spike output
  bit mpend;     // a tick was accepted; threshold evaluation is due
  int mleft;     // refractory ticks still to wait

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int leak(input int v);
    int d, q;
    d = 1 << SHIFT_I;
    q = (v >= 0) ? v / d : -((-v + d - 1) / d);   // floor(v / 2^shift)
    return v - q;
  endfunction

  task automatic model_reset();
    mv = 0; mcnt = 0; mspk = 0; mpend = 0; mleft = 0;
  endtask

  task automatic model_step(input bit wv, input int w, input bit tk, input bit kl);
    int ws;
    ws = (w > 127) ? w - 256 : w;
    mspk = 0;
    if (kl) begin
      model_reset();
    end else if (mpend) begin
      mpend = 0;
      if (mv >= VTH_I) begin
        mspk  = 1;
        mv    = 0;
        mcnt  = (mcnt + 1) % 65536;
        mleft = REF_I;
      end else begin
`ifdef LIF_LEAK_EN
        mv = leak(mv);
`endif
      end
    end else if (mleft > 0) begin
      mv = 0;
      if (tk) mleft--;
    end else begin
      if (wv) mv = sat16(mv + ws);
      if (tk) mpend = 1;
    end
  endtask

  task automatic check_all();
    logic [15:0] ev;
    logic [15:0] ec;
    ev = mv[15:0];
    ec = mcnt[15:0];
    chk("vmem",  vmem_out, ev);
    chk("spike", {15'd0, spike_out}, {15'd0, mspk});
    chk("cnt",   spike_cnt, ec);
    chk("ready", {15'd0, bus.in_ready}, {15'd0, (!mpend && mleft == 0)});
  endtask

  // One clock: drive inputs, advance the model at the edge, check #1 later.
  task automatic cyc(input bit wv, input int w, input bit tk, input bit kl);
    logic [7:0] wb;
    wb = w[7:0];
    bus.w_valid = wv;
    bus.w_in    = wb;
    tick        = tk;
    kill        = kl;
    @(posedge clk);
    model_step(wv, w, tk, kl);
    #1;
    check_all();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    bit prev_tk;
    bit tk, wv, kl;
    int w;

    bus.w_valid = 1'b0;
    bus.w_in    = '0;
    model_reset();

    // Reset state, then release away from the clock edge
    #12;
    check_all();
    rst = 1'b1;
    idle();
    idle();

    // Asynchronous reset mid-integration
    cyc(1, 100, 0, 0);
    cyc(1, 50, 0, 0);
    chk("pre_rst_vmem", vmem_out, 16'd150);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_vmem", vmem_out, 16'd0);
    #2;
    rst = 1'b1;

    // Accumulate and fire
    cyc(1, 8'h64, 0, 0);
    cyc(1, 8'h64, 0, 0);
    cyc(1, 8'h64, 0, 0);
    chk("acc_vmem", vmem_out, 16'd300);
    cyc(0, 0, 1, 0);
    chk("eval_ready", {15'd0, bus.in_ready}, 16'd0);
    cyc(1, 5, 0, 0);
    chk("fire_spike", {15'd0, spike_out}, 16'd1);
    chk("fire_vmem", vmem_out, 16'd0);
    chk("fire_cnt", spike_cnt, 16'd1);
    cyc(1, 5, 0, 0);
    chk("spike_once", {15'd0, spike_out}, 16'd0);
    cyc(1, 7, 1, 0);
    chk("refrac_ready1", {15'd0, bus.in_ready}, 16'd0);
    cyc(1, 7, 0, 0);
    chk("refrac_vmem", vmem_out, 16'd0);
    cyc(0, 0, 1, 0);
    chk("refrac_exit", {15'd0, bus.in_ready}, 16'd1);

    // Leak
    cyc(1, 8'h50, 0, 0);
    cyc(0, 0, 1, 0);
    idle();
`ifdef LIF_LEAK_EN
    chk("leak1", vmem_out, 16'd70);
`else
    chk("leak1", vmem_out, 16'd80);
`endif
    idle();
    cyc(0, 0, 1, 0);
    idle();
`ifdef LIF_LEAK_EN
    chk("leak2", vmem_out, 16'd62);
`else
    chk("leak2", vmem_out, 16'd80);
`endif
    cyc(0, 0, 0, 1);

    // Weight and tick in the same cycle
    cyc(1, 100, 0, 0);
    cyc(1, 100, 0, 0);
    cyc(1, 56, 1, 0);
    chk("same_vmem", vmem_out, 16'd256);
    idle();
    chk("same_spike", {15'd0, spike_out}, 16'd1);
    cyc(0, 0, 1, 0);
    idle();
    cyc(0, 0, 1, 0);

    // Negative saturation, then leak from the rail
    for (int i = 0; i < 300; i++) cyc(1, 8'h80, 0, 0);
    chk("sat_vmem", vmem_out, 16'h8000);
    cyc(0, 0, 1, 0);
    idle();
`ifdef LIF_LEAK_EN
    chk("sat_leak", vmem_out, 16'h9000);
`else
    chk("sat_leak", vmem_out, 16'h8000);
`endif

    // kill during refractory
    cyc(0, 0, 0, 1);
    cyc(1, 8'h7F, 0, 0);
    cyc(1, 8'h7F, 0, 0);
    cyc(1, 8'h7F, 1, 0);
    idle();
    chk("kill_pre_spike", {15'd0, spike_out}, 16'd1);
    cyc(0, 0, 0, 1);
    chk("kill_vmem", vmem_out, 16'd0);
    chk("kill_cnt", spike_cnt, 16'd0);
    chk("kill_ready", {15'd0, bus.in_ready}, 16'd1);
    cyc(1, 10, 0, 0);
    chk("kill_then_w", vmem_out, 16'd10);

    // Randomized traffic; ticks never on consecutive cycles
    prev_tk = 0;
    for (int i = 0; i < 2000; i++) begin
      wv = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 255);
      tk = !prev_tk && ($urandom_range(0, 5) == 0);
      kl = ($urandom_range(0, 299) == 0);
      cyc(wv, w, tk, kl);
      prev_tk = tk;
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
